// File: rtl/dma_axi64_cmd_arb_pkg.sv
// dma_axi64_cmd_arb_pkg: shared widths, FSM state type and round-robin helper for the command arbiter
package dma_axi64_cmd_arb_pkg;

    localparam int ID_BITS   = 4;
    localparam int LEN_BITS  = 4;
    localparam int SIZE_BITS = 3;
    localparam int OUTS_BITS = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } cmd_state_e;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 == n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/dma_axi64_rr_arb.sv
// dma_axi64_rr_arb: combinational round-robin pick, lowest requesting index at or after the pointer wins
module dma_axi64_rr_arb #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         vld_o
);

    // scan from the farthest offset down so the nearest request to the pointer overrides
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                idx_o = W'((int'(ptr_i) + k) % N);
                vld_o = 1'b1;
            end
        end
        gnt_o = vld_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/dma_axi64_cmd_arb.sv
// dma_axi64_cmd_arb: round-robin AR/AW command arbiter with per-direction outstanding-burst limit
module dma_axi64_cmd_arb
    import dma_axi64_cmd_arb_pkg::*;
#(
    parameter int CH_NUM   = 8,
    parameter int MAX_OUTS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CH_NUM-1:0]             ch_rd_req,
    input  logic [CH_NUM*32-1:0]          ch_rd_addr,
    input  logic [CH_NUM*LEN_BITS-1:0]    ch_rd_len,
    input  logic [CH_NUM*SIZE_BITS-1:0]   ch_rd_size,
    output logic [CH_NUM-1:0]             ch_rd_gnt,
    input  logic [CH_NUM-1:0]             ch_wr_req,
    input  logic [CH_NUM*32-1:0]          ch_wr_addr,
    input  logic [CH_NUM*LEN_BITS-1:0]    ch_wr_len,
    input  logic [CH_NUM*SIZE_BITS-1:0]   ch_wr_size,
    output logic [CH_NUM-1:0]             ch_wr_gnt,
    output logic [ID_BITS-1:0]            ARID0,
    output logic [31:0]                   ARADDR0,
    output logic [LEN_BITS-1:0]           ARLEN0,
    output logic [SIZE_BITS-1:0]          ARSIZE0,
    output logic                          ARVALID0,
    input  logic                          ARREADY0,
    output logic [ID_BITS-1:0]            AWID0,
    output logic [31:0]                   AWADDR0,
    output logic [LEN_BITS-1:0]           AWLEN0,
    output logic [SIZE_BITS-1:0]          AWSIZE0,
    output logic                          AWVALID0,
    input  logic                          AWREADY0,
    input  logic                          RVALID0,
    input  logic                          RREADY0,
    input  logic                          RLAST0,
    input  logic                          BVALID0,
    input  logic                          BREADY0,
    output logic [OUTS_BITS-1:0]          rd_outs,
    output logic [OUTS_BITS-1:0]          wr_outs,
    output logic                          idle
);

    localparam int PW = $clog2(CH_NUM);

    cmd_state_e            rd_state_q, rd_state_d, wr_state_q, wr_state_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_pick_idx, wr_pick_idx, rd_win_q, wr_win_q;
    logic [CH_NUM-1:0]     rd_pick_oh, wr_pick_oh, rd_oh_q, wr_oh_q;
    logic                  rd_pick_vld, wr_pick_vld, rd_load, wr_load;
    logic                  rd_hs, wr_hs, rd_done, wr_done;
    logic [OUTS_BITS-1:0]  rd_outs_q, rd_outs_d, wr_outs_q, wr_outs_d;
    logic [31:0]           rd_addr_q, wr_addr_q;
    logic [LEN_BITS-1:0]   rd_len_q, wr_len_q;
    logic [SIZE_BITS-1:0]  rd_size_q, wr_size_q;

    dma_axi64_rr_arb #(.N(CH_NUM), .W(PW)) u_rd_arb (
        .req_i (ch_rd_req),
        .ptr_i (rd_ptr_q),
        .gnt_o (rd_pick_oh),
        .idx_o (rd_pick_idx),
        .vld_o (rd_pick_vld)
    );

    dma_axi64_rr_arb #(.N(CH_NUM), .W(PW)) u_wr_arb (
        .req_i (ch_wr_req),
        .ptr_i (wr_ptr_q),
        .gnt_o (wr_pick_oh),
        .idx_o (wr_pick_idx),
        .vld_o (wr_pick_vld)
    );

    assign ARVALID0 = rd_state_q == ST_VALID;
    assign AWVALID0 = wr_state_q == ST_VALID;
    assign ARID0    = ID_BITS'(rd_win_q);
    assign AWID0    = ID_BITS'(wr_win_q);
    assign ARADDR0  = rd_addr_q;
    assign AWADDR0  = wr_addr_q;
    assign ARLEN0   = rd_len_q;
    assign AWLEN0   = wr_len_q;
    assign ARSIZE0  = rd_size_q;
    assign AWSIZE0  = wr_size_q;
    assign rd_outs  = rd_outs_q;
    assign wr_outs  = wr_outs_q;

    assign rd_hs   = ARVALID0 & ARREADY0;
    assign wr_hs   = AWVALID0 & AWREADY0;
    assign rd_done = RVALID0 & RREADY0 & RLAST0;
    assign wr_done = BVALID0 & BREADY0;

    assign idle = ~ARVALID0 & ~AWVALID0 & (rd_outs_q == '0) & (wr_outs_q == '0)
                & ~|ch_rd_req & ~|ch_wr_req;

    // read FSM next state: latch a winner when not full, release it on the AR handshake
    always_comb begin
        rd_state_d = rd_state_q;
        rd_ptr_d   = rd_ptr_q;
        rd_load    = 1'b0;
        ch_rd_gnt  = '0;
        if (rd_state_q == ST_IDLE) begin
            if (rd_pick_vld && rd_outs_q != OUTS_BITS'(MAX_OUTS)) begin
                rd_load    = 1'b1;
                rd_state_d = ST_VALID;
            end
        end else if (ARREADY0) begin
            ch_rd_gnt  = rd_oh_q;
            rd_ptr_d   = PW'(rr_next(32'(rd_win_q), CH_NUM));
            rd_state_d = ST_IDLE;
        end
    end

    // write FSM next state: same policy on the AW channel
    always_comb begin
        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_load    = 1'b0;
        ch_wr_gnt  = '0;
        if (wr_state_q == ST_IDLE) begin
            if (wr_pick_vld && wr_outs_q != OUTS_BITS'(MAX_OUTS)) begin
                wr_load    = 1'b1;
                wr_state_d = ST_VALID;
            end
        end else if (AWREADY0) begin
            ch_wr_gnt  = wr_oh_q;
            wr_ptr_d   = PW'(rr_next(32'(wr_win_q), CH_NUM));
            wr_state_d = ST_IDLE;
        end
    end

    // outstanding counters: issue and completion together cancel, completion at zero is dropped
    always_comb begin
        rd_outs_d = (rd_hs & ~rd_done) ? rd_outs_q + 1'b1
                  : (~rd_hs & rd_done & (rd_outs_q != '0)) ? rd_outs_q - 1'b1 : rd_outs_q;
        wr_outs_d = (wr_hs & ~wr_done) ? wr_outs_q + 1'b1
                  : (~wr_hs & wr_done & (wr_outs_q != '0)) ? wr_outs_q - 1'b1 : wr_outs_q;
    end

    // state, pointer and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state_q <= ST_IDLE;
            wr_state_q <= ST_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_outs_q  <= '0;
            wr_outs_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_outs_q  <= rd_outs_d;
            wr_outs_q  <= wr_outs_d;
        end
    end

    // read payload captured from the winning channel when the command is latched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_win_q  <= '0;
            rd_oh_q   <= '0;
            rd_addr_q <= '0;
            rd_len_q  <= '0;
            rd_size_q <= '0;
        end else if (rd_load) begin
            rd_win_q  <= rd_pick_idx;
            rd_oh_q   <= rd_pick_oh;
            rd_addr_q <= ch_rd_addr[32*rd_pick_idx +: 32];
            rd_len_q  <= ch_rd_len[LEN_BITS*rd_pick_idx +: LEN_BITS];
            rd_size_q <= ch_rd_size[SIZE_BITS*rd_pick_idx +: SIZE_BITS];
        end
    end

    // write payload captured from the winning channel when the command is latched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_win_q  <= '0;
            wr_oh_q   <= '0;
            wr_addr_q <= '0;
            wr_len_q  <= '0;
            wr_size_q <= '0;
        end else if (wr_load) begin
            wr_win_q  <= wr_pick_idx;
            wr_oh_q   <= wr_pick_oh;
            wr_addr_q <= ch_wr_addr[32*wr_pick_idx +: 32];
            wr_len_q  <= ch_wr_len[LEN_BITS*wr_pick_idx +: LEN_BITS];
            wr_size_q <= ch_wr_size[SIZE_BITS*wr_pick_idx +: SIZE_BITS];
        end
    end

endmodule

// File: doc/dma_axi64_cmd_arb.md
# dma_axi64_cmd_arb

Command arbiter for the 64-bit AXI master port of the DMA. It shares the single AR and AW command channels between CH_NUM DMA channels using independent round-robin arbitration per direction. It tags each command with the winning channel number as AXI ID and limits outstanding bursts per direction. It sits between the per-channel read/write command generators and the AR/AW ports of the AXI master (e.g. toward axi_slave in the wrap).

## Interface
- CH_NUM, 8, number of DMA channels; 2..16, with `ID_BITS >= clog2(CH_NUM)
- MAX_OUTS, 4, max outstanding bursts per direction; 1..15
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ch_rd_req  in  CH_NUM  per-channel read command request; held until granted
- ch_rd_addr  in  CH_NUM*32  packed read addresses; channel i at [32*i+31:32*i]
- ch_rd_len  in  CH_NUM*`LEN_BITS  packed burst lengths
- ch_rd_size  in  CH_NUM*`SIZE_BITS  packed burst sizes
- ch_rd_gnt  out  CH_NUM  one-hot pulse on the AR handshake of that channel's command
- ch_wr_req, ch_wr_addr, ch_wr_len, ch_wr_size, ch_wr_gnt  same as the read set, for writes
- ARID0 / ARADDR0 / ARLEN0 / ARSIZE0  out  `ID_BITS / 32 / `LEN_BITS / `SIZE_BITS  read command payload
- ARVALID0 out 1, ARREADY0 in 1  AR handshake
- AWID0 / AWADDR0 / AWLEN0 / AWSIZE0 / AWVALID0 out, AWREADY0 in  write command, same widths
- RVALID0, RREADY0, RLAST0  in  1 each  read completion observation
- BVALID0, BREADY0  in  1 each  write completion observation
- rd_outs, wr_outs  out  4  current outstanding burst counts
- idle  out  1  no command valid and both counters zero

## Operation
- The read and write paths are identical and independent. Each has a 2-state FSM:
  - IDLE: if any req is set and outs < MAX_OUTS, register the round-robin winner's ID/addr/len/size and go to VALID.
  - VALID: assert xVALID0. When xREADY0 is high, pulse gnt[winner] combinationally in that cycle, move the priority pointer to winner+1 (mod CH_NUM), and return to IDLE.
- Round-robin search starts at the pointer; the lowest index at or after the pointer wins. Pointer reset value is 0.
- ID = winner index, zero-extended to `ID_BITS.
- Outstanding counter:
  - +1 on AR (AW) handshake.
  - −1 on RVALID0&RREADY0&RLAST0 (BVALID0&BREADY0).
  - Both in the same cycle: unchanged.
  - A decrement at 0 is ignored (counter saturates at 0).
- Full (outs == MAX_OUTS): the FSM stays in IDLE and requests wait. A decrement in the same cycle does not enable arbitration until the next cycle.
- A request dropped by a channel before its grant is a protocol violation; the latched command is still issued.
- idle = (both FSMs in IDLE) & (rd_outs == 0) & (wr_outs == 0) & ~|ch_rd_req & ~|ch_wr_req.

## Timing
- Reset values: all xVALID0 = 0, payload = 0, gnt = 0, outs = 0, idle = 1, FSMs in IDLE, pointers = 0.
- Reset mid-burst drops xVALID0 immediately (asynchronous) and clears the counters.
- Latency: request high in cycle N (IDLE, not full) → xVALID0 high in cycle N+1.
- Peak throughput is one command per 2 cycles per direction (IDLE turnaround).
- xVALID0 and payload are registered and stable from assertion until the handshake; xVALID0 never deasserts without xREADY0.
- gnt is combinational from state & xREADY0 and is high only in the handshake cycle.
- The counter updates on the clock edge after the handshake or completion.

## Structure
- Constants `ID_BITS, `LEN_BITS and `SIZE_BITS come from the shared dma_axi64 defines file. The FSM state encoding (IDLE=0, VALID=1) is local.
- Sub-module dma_axi64_rr_arb: combinational CH_NUM-way round-robin pick (req, ptr → one-hot winner + index). It is instantiated once per direction.
- Top level: two FSM/counter/payload-register slices plus the idle logic.

## Test plan
- Single read: ch_rd_req[3]=1, addr 0x1000, len 7, ARREADY0=1 → ARVALID0 on cycle 2, ARID0=3, ARADDR0=0x1000, ch_rd_gnt=0x08 on the handshake, rd_outs=1; RLAST0 beat → rd_outs=0, idle=1.
- Fairness: ch_rd_req=0xFF held, ARREADY0=1 → ARIDs issued 0,1,2,…,7,0.
- Backpressure: ARREADY0=0 for 5 cycles → ARVALID0 and payload unchanged, no gnt; ARREADY0=1 → one gnt pulse.
- Throttle: MAX_OUTS=4, no R completions → 4 ARs issued, then ARVALID0 stays 0; one RLAST0 → a 5th AR follows 2 cycles later.
- Simultaneous events: AW handshake and B completion in the same cycle at wr_outs=2 → wr_outs stays 2; concurrent read and write requests both issue in parallel.
- Reset asserted while ARVALID0=1 → ARVALID0=0 immediately; all outputs at reset values; pointer=0 after release.
